traffic_phase_ctrl: RTL

//  Sequences a two-road (NS/EW) intersection with a pedestrian walk phase.
//  Has an internal clk prescaler that produces a 1-cycle tick; all phase timing counts ticks.

---
 rtl/traffic_phase_ctrl.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/traffic_phase_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_phase_ctrl
//
// Purpose:
//   Phase sequencer for a two-road (NS/EW) intersection with a pedestrian
//   walk phase. An internal prescaler turns the board clock into a one-cycle
//   tick. All phase durations are counted in ticks. The tick is an enable
//   only. Every flop runs on clk, and no divided clock is generated.
//
// Build option:
//   NIGHT_FLASH_EN  When defined, the module gains a `night` input and a
//                   FLASH state (encoding 7). In FLASH, both roads blink
//                   yellow. When undefined, neither the input nor the state
//                   exists, and encoding 7 is never produced.
//
// Parameters:
//   TICK_DIV  clk cycles per tick (>= 2)
//   GREEN_T   ticks per green phase (>= 1)
//   YELLOW_T  ticks per yellow phase (>= 1)
//   ALLRED_T  ticks per all-red clearance (>= 1)
//   WALK_T    ticks per pedestrian walk phase (>= 1)
//   CNT_W     phase-counter width. It must hold max(*_T)-1.
//
// Ports:
//   clk       in   1  single clock, all logic on posedge
//   reset     in   1  asynchronous, active-low reset
//   night     in   1  night-flash request (NIGHT_FLASH_EN builds only)
//   ped_req   in   1  pedestrian request, any-length pulse
//   ns_light  out  3  {red,yellow,green} for NS, one-hot (registered)
//   ew_light  out  3  {red,yellow,green} for EW, one-hot (registered)
//   walk      out  1  pedestrian walk lamp (registered)
//   ped_ack   out  1  one-cycle pulse on the first cycle of PED_WALK
//   phase     out  3  current state encoding (debug)
//   tick      out  1  prescaler tick, high while presc == TICK_DIV-1
// ---------------------------------------------------------------------------
module traffic_phase_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 5,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
`ifdef NIGHT_FLASH_EN
  input  logic       night,
`endif
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase,
  output logic       tick
);

  localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED1  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED2  = 3'd5,
    PED_WALK  = 3'd6
`ifdef NIGHT_FLASH_EN
    ,
    FLASH     = 3'd7
`endif
  } state_t;

  // Select which green follows PED_WALK.
  localparam logic ROAD_NS = 1'b0;
  localparam logic ROAD_EW = 1'b1;

  // Registers
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_q, tick_d;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ped_pend_q, ped_pend_d;
  logic               next_road_q, next_road_d;
  logic [2:0]         ns_light_q, ns_light_d;
  logic [2:0]         ew_light_q, ew_light_d;
  logic               walk_q, walk_d;
  logic               ped_ack_q, ped_ack_d;
`ifdef NIGHT_FLASH_EN
  logic               blink_q, blink_d;
`endif

  // This is asserted on the edge where the state register moves into
  // PED_WALK. It drives both the pending-request clear and the ack.
  logic enter_walk;

  // Return the last counter value of a phase, i.e. DUR(state) - 1.
  function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   dur_m1 = CNT_W'(GREEN_T - 1);
      NS_YELLOW, EW_YELLOW: dur_m1 = CNT_W'(YELLOW_T - 1);
      PED_WALK:             dur_m1 = CNT_W'(WALK_T - 1);
      default:              dur_m1 = CNT_W'(ALLRED_T - 1);
    endcase
  endfunction

  // Decode the lamps from a state. A road is red everywhere except in its
  // own green and yellow phases. FLASH is handled separately by the caller.
  function automatic logic [2:0] ns_decode(input state_t s);
    case (s)
      NS_GREEN:  ns_decode = LAMP_GREEN;
      NS_YELLOW: ns_decode = LAMP_YELLOW;
      default:   ns_decode = LAMP_RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_decode(input state_t s);
    case (s)
      EW_GREEN:  ew_decode = LAMP_GREEN;
      EW_YELLOW: ew_decode = LAMP_YELLOW;
      default:   ew_decode = LAMP_RED;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    presc_d     = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
    // The tick is registered. It is computed from the next prescaler value,
    // so tick_q is high during exactly the cycle where presc_q is at its
    // last value.
    tick_d      = (presc_d == PRESC_LAST);
    state_d     = state_q;
    cnt_d       = cnt_q;
    next_road_d = next_road_q;
    enter_walk  = 1'b0;
`ifdef NIGHT_FLASH_EN
    blink_d     = blink_q;
`endif

    if (tick_q) begin
`ifdef NIGHT_FLASH_EN
      if (night) begin
        // Enter FLASH (or stay in it). The blink starts lit on entry and
        // toggles on every later tick.
        state_d = FLASH;
        cnt_d   = '0;
        blink_d = (state_q == FLASH) ? ~blink_q : 1'b1;
      end else if (state_q == FLASH) begin
        state_d = ALL_RED2;
        cnt_d   = '0;
      end else
`endif
      begin
        if (cnt_q == dur_m1(state_q)) begin
          cnt_d = '0;
          case (state_q)
            NS_GREEN:  state_d = NS_YELLOW;
            NS_YELLOW: state_d = ALL_RED1;
            ALL_RED1: begin
              if (ped_pend_q) begin
                state_d     = PED_WALK;
                next_road_d = ROAD_EW;
                enter_walk  = 1'b1;
              end else begin
                state_d = EW_GREEN;
              end
            end
            EW_GREEN:  state_d = EW_YELLOW;
            EW_YELLOW: state_d = ALL_RED2;
            ALL_RED2: begin
              if (ped_pend_q) begin
                state_d     = PED_WALK;
                next_road_d = ROAD_NS;
                enter_walk  = 1'b1;
              end else begin
                state_d = NS_GREEN;
              end
            end
            PED_WALK:  state_d = (next_road_q == ROAD_EW) ? EW_GREEN : NS_GREEN;
            default:   state_d = ALL_RED2;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // Set wins over clear. A request arriving on the entry cycle is kept
    // for the next all-red phase.
    ped_pend_d = ped_req | (ped_pend_q & ~enter_walk);
    ped_ack_d  = enter_walk;

    // Compute the lamps from the next state. The registered outputs then
    // change on the same edge as the state.
    ns_light_d = ns_decode(state_d);
    ew_light_d = ew_decode(state_d);
    walk_d     = (state_d == PED_WALK);
`ifdef NIGHT_FLASH_EN
    if (state_d == FLASH) begin
      ns_light_d = {1'b0, blink_d, 1'b0};
      ew_light_d = {1'b0, blink_d, 1'b0};
      walk_d     = 1'b0;
    end
`endif
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q     <= '0;
      tick_q      <= 1'b0;
      state_q     <= ALL_RED2;
      cnt_q       <= '0;
      ped_pend_q  <= 1'b0;
      next_road_q <= ROAD_NS;
      ns_light_q  <= LAMP_RED;
      ew_light_q  <= LAMP_RED;
      walk_q      <= 1'b0;
      ped_ack_q   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ped_pend_q  <= ped_pend_d;
      next_road_q <= next_road_d;
      ns_light_q  <= ns_light_d;
      ew_light_q  <= ew_light_d;
      walk_q      <= walk_d;
      ped_ack_q   <= ped_ack_d;
    end
  end

`ifdef NIGHT_FLASH_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_q <= 1'b1;
    end else begin
      blink_q <= blink_d;
    end
  end
`endif

  assign ns_light = ns_light_q;
  assign ew_light = ew_light_q;
  assign walk     = walk_q;
  assign ped_ack  = ped_ack_q;
  assign phase    = state_q;
  assign tick     = tick_q;

endmodule
